// File: rtl/pic_step_sequencer_pkg.sv
// Shared types and default sizes for the PIC timestep sequencer and its grid memories.
package pic_step_sequencer_pkg;

  localparam int unsigned NUM_PARTICLES = 16384;
  localparam int unsigned NUM_CELLS     = 4096;
  localparam int unsigned NUM_IT        = 4;
  localparam int unsigned PADDRWIDTH    = $clog2(NUM_PARTICLES);

  // Grid memory ownership: scatter writes charge, solve reads charge and writes phi.
  typedef enum logic {
    SCATTER = 1'b0,
    SOLVE   = 1'b1
  } step_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SCAT_ISSUE = 3'd1,
    SCAT_DRAIN = 3'd2,
    SOLV_ISSUE = 3'd3,
    SOLV_DRAIN = 3'd4
  } seq_state_t;

endpackage

// File: rtl/pic_step_sequencer_idx_streamer.sv
// Valid/ready index source: presents 0..N-1 while enabled, pulses last on the final handshake
// and wraps back to 0 so the next pass starts clean.
module pic_step_sequencer_idx_streamer #(
  parameter int unsigned N = 4,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ready,
  output logic [W-1:0] addr,
  output logic         valid,
  output logic         last
);

  logic [W-1:0] addr_q;
  logic         fire;

  // valid follows the enable directly; the owner only drops en after the last handshake
  assign valid = en;
  assign fire  = en && ready;
  assign last  = fire && (addr_q == W'(N - 1));
  assign addr  = addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else if (fire) begin
      addr_q <= last ? '0 : addr_q + W'(1);
    end
  end

endmodule

// File: rtl/pic_step_sequencer.sv
// PIC timestep sequencer: per step, scatter every particle, drain, then run NUM_IT solver
// sweeps over every cell, draining after each; repeats for num_steps timesteps.
module pic_step_sequencer
  import pic_step_sequencer_pkg::*;
#(
  parameter int unsigned NUM_PARTICLES = 16384,
  parameter int unsigned NUM_CELLS     = pic_step_sequencer_pkg::NUM_CELLS,
  parameter int unsigned NUM_IT        = pic_step_sequencer_pkg::NUM_IT,
  parameter int unsigned PADDRW        = $clog2(NUM_PARTICLES),
  parameter int unsigned GADDRW        = $clog2(NUM_CELLS),
  parameter int unsigned ITW           = $clog2(NUM_IT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [15:0]       num_steps,
  output logic              busy,
  output logic              done,
  output step_t             step,
  output logic [PADDRW-1:0] part_addr,
  output logic              part_valid,
  input  logic              part_ready,
  input  logic              scatter_idle,
  output logic [GADDRW-1:0] cell_addr,
  output logic              cell_valid,
  input  logic              cell_ready,
  input  logic              solve_idle,
  output logic [ITW-1:0]    iter,
  output logic [15:0]       step_count
);

  seq_state_t  state_q, state_d;
  logic [ITW-1:0] iter_q, iter_d;
  logic [15:0] step_count_q, step_count_d;
  logic [15:0] num_steps_q, num_steps_d;
  logic        done_q, done_d;
  logic        part_last, cell_last;

  pic_step_sequencer_idx_streamer #(
    .N (NUM_PARTICLES),
    .W (PADDRW)
  ) u_part_stream (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == SCAT_ISSUE),
    .ready (part_ready),
    .addr  (part_addr),
    .valid (part_valid),
    .last  (part_last)
  );

  pic_step_sequencer_idx_streamer #(
    .N (NUM_CELLS),
    .W (GADDRW)
  ) u_cell_stream (
    .clk   (clk),
    .rst   (rst),
    .en    (state_q == SOLV_ISSUE),
    .ready (cell_ready),
    .addr  (cell_addr),
    .valid (cell_valid),
    .last  (cell_last)
  );

  always_comb begin
    state_d      = state_q;
    iter_d       = iter_q;
    step_count_d = step_count_q;
    num_steps_d  = num_steps_q;
    done_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          step_count_d = '0;
          num_steps_d  = num_steps;
          if (num_steps != 16'd0) begin
            state_d = SCAT_ISSUE;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      SCAT_ISSUE: if (part_last) state_d = SCAT_DRAIN;
      SCAT_DRAIN: if (scatter_idle) state_d = SOLV_ISSUE;
      SOLV_ISSUE: if (cell_last) state_d = SOLV_DRAIN;
      SOLV_DRAIN: begin
        if (solve_idle) begin
          if (iter_q < ITW'(NUM_IT - 1)) begin
            iter_d  = iter_q + ITW'(1);
            state_d = SOLV_ISSUE;
          end else begin
            iter_d       = '0;
            step_count_d = step_count_q + 16'd1;
            // widened compare so a 16-bit step_count never wraps into a false "more to do"
            if (({1'b0, step_count_q} + 17'd1) < {1'b0, num_steps_q}) begin
              state_d = SCAT_ISSUE;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      iter_q       <= '0;
      step_count_q <= '0;
      num_steps_q  <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      iter_q       <= iter_d;
      step_count_q <= step_count_d;
      num_steps_q  <= num_steps_d;
      done_q       <= done_d;
    end
  end

  // Ownership is a pure function of state, so it only flips on drain->issue edges.
  assign step       = ((state_q == SOLV_ISSUE) || (state_q == SOLV_DRAIN)) ? SOLVE : SCATTER;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign iter       = iter_q;
  assign step_count = step_count_q;

endmodule

// File: tb/tb_pic_step_sequencer.sv
// Scoreboard bench for pic_step_sequencer with 8 particles, 4 cells and 2 sweeps per step.
module tb_pic_step_sequencer;
  import pic_step_sequencer_pkg::*;

  localparam int NP  = 8;
  localparam int NC  = 4;
  localparam int NIT = 2;

  typedef struct {
    int kind;  // 0 particle handshake, 1 cell handshake, 2 done pulse
    int addr;  // address, or expected step_count for done
    int it;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] num_steps;
  logic        busy, done;
  step_t       step;
  logic [2:0]  part_addr;
  logic        part_valid, part_ready, scatter_idle;
  logic [1:0]  cell_addr;
  logic        cell_valid, cell_ready, solve_idle;
  logic [1:0]  iter;
  logic [15:0] step_count;

  exp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   n_part = 0, n_cell = 0, flips = 0;
  int   part_mode = 0, cell_mode = 0;
  int   scat_hold = 3, solv_hold = 3;
  int   scat_cnt = 0, solv_cnt = 0;
  logic part_hs = 0, cell_hs = 0;
  logic prev_pstall = 0, prev_cstall = 0;
  logic [2:0] prev_paddr = '0;
  logic [1:0] prev_caddr = '0;
  step_t prev_step = SCATTER;

  pic_step_sequencer #(
    .NUM_PARTICLES (NP),
    .NUM_CELLS     (NC),
    .NUM_IT        (NIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_steps    (num_steps),
    .busy         (busy),
    .done         (done),
    .step         (step),
    .part_addr    (part_addr),
    .part_valid   (part_valid),
    .part_ready   (part_ready),
    .scatter_idle (scatter_idle),
    .cell_addr    (cell_addr),
    .cell_valid   (cell_valid),
    .cell_ready   (cell_ready),
    .solve_idle   (solve_idle),
    .iter         (iter),
    .step_count   (step_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  task automatic pop_check(input int kind, input int addr, input int it);
    exp_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_event: got kind %0d addr %0d, expected nothing (t=%0t)",
               kind, addr, $time);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", kind, e.kind);
      check("event_addr", addr, e.addr);
      check("event_iter", it, e.it);
    end
  endtask

  function automatic void push_ev(input int kind, input int addr, input int it);
    exp_t e;
    e.kind = kind;
    e.addr = addr;
    e.it   = it;
    exp_q.push_back(e);
  endfunction

  function automatic void push_run(input int n);
    for (int s = 0; s < n; s++) begin
      for (int a = 0; a < NP; a++) push_ev(0, a, 0);
      for (int it = 0; it < NIT; it++) begin
        for (int a = 0; a < NC; a++) push_ev(1, a, it);
      end
    end
    push_ev(2, n, 0);
  endfunction

  // Monitor: every handshake or done pulse the DUT presents is checked against the queue.
  always @(negedge clk) begin
    part_hs = 1'b0;
    cell_hs = 1'b0;
    if (!rst) begin
      if (part_valid && cell_valid) check("both_valid", 1, 0);
      if (prev_pstall) check("part_hold", part_valid ? int'(part_addr) : -1, int'(prev_paddr));
      if (prev_cstall) check("cell_hold", cell_valid ? int'(cell_addr) : -1, int'(prev_caddr));
      if (prev_step == SCATTER && step == SOLVE) flips++;
      if (part_valid && part_ready) begin
        part_hs = 1'b1;
        n_part++;
        pop_check(0, int'(part_addr), 0);
        check("part_step", int'(step), int'(SCATTER));
      end
      if (cell_valid && cell_ready) begin
        cell_hs = 1'b1;
        n_cell++;
        pop_check(1, int'(cell_addr), int'(iter));
        check("cell_step", int'(step), int'(SOLVE));
      end
      if (done) begin
        pop_check(2, int'(step_count), 0);
        check("done_busy", int'(busy), 0);
      end
    end
    prev_pstall = !rst && part_valid && !part_ready;
    prev_cstall = !rst && cell_valid && !cell_ready;
    prev_paddr  = part_addr;
    prev_caddr  = cell_addr;
    prev_step   = step;
  end

  // Downstream model: ready patterns and idle flags that drop on traffic and recover later.
  initial begin
    part_ready   = 1'b1;
    cell_ready   = 1'b1;
    scatter_idle = 1'b1;
    solve_idle   = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      part_ready = (part_mode == 1) ? !part_ready : 1'b1;
      cell_ready = (cell_mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (part_hs) begin
        scatter_idle = 1'b0;
        scat_cnt     = scat_hold;
      end else if (!scatter_idle) begin
        if (scat_cnt <= 1) scatter_idle = 1'b1;
        else scat_cnt--;
      end
      if (cell_hs) begin
        solve_idle = 1'b0;
        solv_cnt   = solv_hold;
      end else if (!solve_idle) begin
        if (solv_cnt <= 1) solve_idle = 1'b1;
        else solv_cnt--;
      end
    end
  end

  task automatic do_start(input int n, input bit check_lat);
    @(negedge clk);
    start     = 1'b1;
    num_steps = 16'(n);
    @(negedge clk);
    start = 1'b0;
    if (check_lat) begin
      if (n > 0) begin
        check("lat_part_valid", int'(part_valid), 1);
        check("lat_busy", int'(busy), 1);
      end else begin
        check("zero_done", int'(done), 1);
        check("zero_busy", int'(busy), 0);
        check("zero_valids", int'(part_valid | cell_valid), 0);
        @(negedge clk);
        check("zero_done_pulse", int'(done), 0);
        check("zero_busy_after", int'(busy), 0);
      end
    end
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    while (exp_q.size() != 0 && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d events outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_step"}, int'(step), int'(SCATTER));
    check({tag, "_valids"}, int'(part_valid | cell_valid), 0);
    check({tag, "_addrs"}, int'(part_addr) + int'(cell_addr), 0);
    check({tag, "_iter"}, int'(iter), 0);
    check({tag, "_step_count"}, int'(step_count), 0);
  endtask

  initial begin
    int bad;
    int c;
    rst       = 1'b1;
    start     = 1'b0;
    num_steps = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;

    // One timestep, ready tied high.
    flips = 0;
    push_run(1);
    do_start(1, 1'b1);
    wait_drain(2000);
    check("t1_flips", flips, 1);
    check("t1_step_count", int'(step_count), 1);

    // Three timesteps with toggling part_ready and random cell_ready stalls.
    part_mode = 1;
    cell_mode = 1;
    n_part    = 0;
    n_cell    = 0;
    push_run(3);
    do_start(3, 1'b1);
    wait_drain(5000);
    check("t2_part_handshakes", n_part, 24);
    check("t2_cell_handshakes", n_cell, 24);
    check("t2_step_count", int'(step_count), 3);
    part_mode = 0;
    cell_mode = 0;
    repeat (2) @(negedge clk);

    // Zero timesteps.
    push_run(0);
    do_start(0, 1'b1);
    wait_drain(50);

    // Scatter drain held off for ~50 cycles.
    scat_hold = 50;
    push_run(1);
    do_start(1, 1'b1);
    c = 0;
    while (!(part_valid && part_ready && part_addr == 3'd7) && c < 200) begin
      @(negedge clk);
      c++;
    end
    check("t4_last_part_seen", int'(c < 200), 1);
    bad = 0;
    repeat (45) begin
      @(negedge clk);
      if (cell_valid || step != SCATTER) bad++;
    end
    check("t4_stall_hold", bad, 0);
    c = 0;
    while (!scatter_idle && c < 100) begin
      @(negedge clk);
      c++;
    end
    check("t4_idle_cell_valid", int'(cell_valid), 0);
    @(negedge clk);
    check("t4_cell_valid_rise", int'(cell_valid), 1);
    check("t4_step_solve", int'(step), int'(SOLVE));
    scat_hold = 3;
    wait_drain(2000);

    // Start re-pulsed mid-run must be ignored.
    push_run(1);
    do_start(1, 1'b1);
    c = 0;
    while (!cell_valid && c < 200) begin
      @(negedge clk);
      c++;
    end
    do_start(5, 1'b0);
    wait_drain(2000);
    repeat (20) @(negedge clk);
    check("t5_step_count", int'(step_count), 1);
    check("t5_busy", int'(busy), 0);

    // Reset in the second timestep's solve pass at cell_addr 2.
    push_run(3);
    do_start(3, 1'b1);
    c = 0;
    @(posedge clk);
    #2;
    while (!(step_count == 16'd1 && cell_valid && cell_addr == 2'd2) && c < 500) begin
      @(posedge clk);
      #2;
      c++;
    end
    check("t6_reached_cell2", int'(c < 500), 1);
    rst = 1'b1;
    @(posedge clk);
    #2;
    check_reset_vals("midrst");
    rst = 1'b0;
    exp_q.delete();
    repeat (20) @(negedge clk);
    push_run(1);
    do_start(1, 1'b1);
    wait_drain(2000);
    check("t6_fresh_step_count", int'(step_count), 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
